fetch_pipe: RTL and testbench

//  Instruction-fetch datapath and pipeline registers driven by the FSM control unit.

---
 rtl/proc_pkg.sv | 15 +
 rtl/fetch_pipe_branch_resolve.sv | 35 +++
 rtl/fetch_pipe.sv | 106 ++++++++++
 tb/tb_fetch_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor constants: datapath widths, the bubble instruction and branch opcodes.
package proc_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;

    localparam logic [7:0] NOP_INSN = 8'h0A;

    localparam logic [3:0] OP_BZ   = 4'b0101;
    localparam logic [3:0] OP_BNZ  = 4'b1001;
    localparam logic [3:0] OP_BPZ  = 4'b1101;
    localparam logic [3:0] OP_STOP = 4'b1111;

endpackage

// File: rtl/fetch_pipe_branch_resolve.sv
// Combinational branch decision for the instruction in IR3 and selection of the next PC.
module branch_resolve
    import proc_pkg::*;
#(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int ADDR_W = proc_pkg::ADDR_W
) (
    input  logic [DATA_W-1:0] ir3,
    input  logic [ADDR_W-1:0] pc3,
    input  logic [ADDR_W-1:0] pc,
    input  logic              N,
    input  logic              Z,
    output logic              br_taken,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] offset;

    // Unknown or non-branch opcodes fall to the default arm and never redirect.
    always_comb begin
        br_taken = 1'b0;
        case (ir3[3:0])
            OP_BZ:   br_taken = Z;
            OP_BNZ:  br_taken = ~Z;
            OP_BPZ:  br_taken = ~N;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        offset  = {{(ADDR_W-4){ir3[7]}}, ir3[7:4]};
        pc_next = br_taken ? (pc3 + ADDR_W'(1) + offset) : (pc + ADDR_W'(1));
    end

endmodule

// File: rtl/fetch_pipe.sv
// Fetch datapath: PC register, IR1..IR4 / PC1..PC3 pipeline shift registers with bubble
// injection, branch redirect from IR3 and a saturating active-cycle counter.
module fetch_pipe
    import proc_pkg::*;
#(
    parameter int              DATA_W   = proc_pkg::DATA_W,
    parameter int              ADDR_W   = proc_pkg::ADDR_W,
    parameter logic [DATA_W-1:0] NOP_INSN = proc_pkg::NOP_INSN,
    parameter int              CNT_W    = proc_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              PCWrite,
    input  logic              PC1_Load,
    input  logic              PC2_Load,
    input  logic              PC3_Load,
    input  logic              IR_1_Load,
    input  logic              IR_2_Load,
    input  logic              IR_3_Load,
    input  logic              IR_4_Load,
    input  logic              IR1Sel,
    input  logic              CounterOn,
    input  logic              N,
    input  logic              Z,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [3:0]        instr,
    output logic [DATA_W-1:0] ir1,
    output logic [DATA_W-1:0] ir2,
    output logic [DATA_W-1:0] ir3,
    output logic [DATA_W-1:0] ir4,
    output logic [ADDR_W-1:0] pc1,
    output logic [ADDR_W-1:0] pc2,
    output logic [ADDR_W-1:0] pc3,
    output logic              br_taken,
    output logic [CNT_W-1:0]  cycle_cnt
);

    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [ADDR_W-1:0] pc1_q, pc1_d, pc2_q, pc2_d, pc3_q, pc3_d;
    logic [DATA_W-1:0] ir1_q, ir1_d, ir2_q, ir2_d, ir3_q, ir3_d, ir4_q, ir4_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_next;

    branch_resolve #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_branch_resolve (
        .ir3     (ir3_q),
        .pc3     (pc3_q),
        .pc      (pc_q),
        .N       (N),
        .Z       (Z),
        .br_taken(br_taken),
        .pc_next (pc_next)
    );

    // Every stage reads pre-edge _q values, so a full load is a true shift.
    always_comb begin
        pc_d  = PCWrite   ? pc_next : pc_q;
        pc1_d = PC1_Load  ? pc_q    : pc1_q;
        pc2_d = PC2_Load  ? pc1_q   : pc2_q;
        pc3_d = PC3_Load  ? pc2_q   : pc3_q;
        ir1_d = IR_1_Load ? (IR1Sel ? imem_rdata : NOP_INSN) : ir1_q;
        ir2_d = IR_2_Load ? ir1_q   : ir2_q;
        ir3_d = IR_3_Load ? ir2_q   : ir3_q;
        ir4_d = IR_4_Load ? ir3_q   : ir4_q;
        cnt_d = (CounterOn && (cnt_q != {CNT_W{1'b1}})) ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            pc1_q <= '0;
            pc2_q <= '0;
            pc3_q <= '0;
            ir1_q <= NOP_INSN;
            ir2_q <= NOP_INSN;
            ir3_q <= NOP_INSN;
            ir4_q <= NOP_INSN;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            pc1_q <= pc1_d;
            pc2_q <= pc2_d;
            pc3_q <= pc3_d;
            ir1_q <= ir1_d;
            ir2_q <= ir2_d;
            ir3_q <= ir3_d;
            ir4_q <= ir4_d;
            cnt_q <= cnt_d;
        end
    end

    assign imem_addr = pc_q;
    assign instr     = ir1_q[3:0];
    assign ir1       = ir1_q;
    assign ir2       = ir2_q;
    assign ir3       = ir3_q;
    assign ir4       = ir4_q;
    assign pc1       = pc1_q;
    assign pc2       = pc2_q;
    assign pc3       = pc3_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed bench for fetch_pipe: expectations are queued as stimulus is applied and
// drained against the DUT outputs after each step.
module tb_fetch_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        PCWrite, PC1_Load, PC2_Load, PC3_Load;
    logic        IR_1_Load, IR_2_Load, IR_3_Load, IR_4_Load;
    logic        IR1Sel, CounterOn, N, Z;
    logic [7:0]  imem_rdata;
    logic [7:0]  imem_addr;
    logic [3:0]  instr;
    logic [7:0]  ir1, ir2, ir3, ir4, pc1, pc2, pc3;
    logic        br_taken;
    logic [15:0] cycle_cnt;

    logic [7:0]  imem [256];

    localparam int S_PC = 0, S_PC1 = 1, S_PC2 = 2, S_PC3 = 3, S_IR1 = 4, S_IR2 = 5,
                   S_IR3 = 6, S_IR4 = 7, S_BR = 8, S_CNT = 9, S_INSTR = 10;

    typedef struct {
        string       tag;
        int          sig;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign imem_rdata = imem[imem_addr];

    fetch_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .PCWrite   (PCWrite),
        .PC1_Load  (PC1_Load),
        .PC2_Load  (PC2_Load),
        .PC3_Load  (PC3_Load),
        .IR_1_Load (IR_1_Load),
        .IR_2_Load (IR_2_Load),
        .IR_3_Load (IR_3_Load),
        .IR_4_Load (IR_4_Load),
        .IR1Sel    (IR1Sel),
        .CounterOn (CounterOn),
        .N         (N),
        .Z         (Z),
        .imem_rdata(imem_rdata),
        .imem_addr (imem_addr),
        .instr     (instr),
        .ir1       (ir1),
        .ir2       (ir2),
        .ir3       (ir3),
        .ir4       (ir4),
        .pc1       (pc1),
        .pc2       (pc2),
        .pc3       (pc3),
        .br_taken  (br_taken),
        .cycle_cnt (cycle_cnt)
    );

    function automatic logic [15:0] get_obs(input int sig);
        case (sig)
            S_PC:    return {8'h00, imem_addr};
            S_PC1:   return {8'h00, pc1};
            S_PC2:   return {8'h00, pc2};
            S_PC3:   return {8'h00, pc3};
            S_IR1:   return {8'h00, ir1};
            S_IR2:   return {8'h00, ir2};
            S_IR3:   return {8'h00, ir3};
            S_IR4:   return {8'h00, ir4};
            S_BR:    return {15'h0, br_taken};
            S_CNT:   return cycle_cnt;
            S_INSTR: return {12'h0, instr};
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sig, input logic [15:0] e);
        sb_item_t it;
        it.tag = tag;
        it.sig = sig;
        it.exp = e;
        sb_q.push_back(it);
    endtask

    task automatic check_sb();
        sb_item_t it;
        logic [15:0] obs;
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            obs = get_obs(it.sig);
            checks++;
            assert (obs === it.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_loads(input logic v);
        PC1_Load  = v; PC2_Load  = v; PC3_Load  = v;
        IR_1_Load = v; IR_2_Load = v; IR_3_Load = v; IR_4_Load = v;
    endtask

    task automatic idle_inputs();
        set_loads(1'b0);
        PCWrite = 1'b0; IR1Sel = 1'b0; CounterOn = 1'b0;
    endtask

    task automatic fill_imem();
        for (int i = 0; i < 256; i++) imem[i] = 8'h30;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic fetch_straight(input int n);
        set_loads(1'b1);
        IR1Sel  = 1'b1;
        PCWrite = 1'b1;
        repeat (n) tick();
        idle_inputs();
    endtask

    // Fetch the branch at addr, stall two bubble cycles, then resolve with PCWrite.
    task automatic branch_seq(input string name, input logic [7:0] addr, input logic [7:0] word,
                              input logic exp_taken, input logic [7:0] exp_pc);
        set_loads(1'b1);
        IR1Sel  = 1'b1;
        PCWrite = 1'b0;
        tick();
        expect_v({name, "_ir1"}, S_IR1, {8'h00, word});
        expect_v({name, "_pc1"}, S_PC1, {8'h00, addr});
        check_sb();
        IR1Sel = 1'b0;
        tick();
        tick();
        expect_v({name, "_ir2_nop"}, S_IR2, 16'h000A);
        expect_v({name, "_ir3"},     S_IR3, {8'h00, word});
        expect_v({name, "_br"},      S_BR,  {15'h0, exp_taken});
        expect_v({name, "_pc_stall"}, S_PC, {8'h00, addr});
        check_sb();
        PCWrite = 1'b1;
        tick();
        expect_v({name, "_pc_after"}, S_PC,  {8'h00, exp_pc});
        expect_v({name, "_ir4"},      S_IR4, {8'h00, word});
        check_sb();
        idle_inputs();
    endtask

    initial begin
        N = 1'b0; Z = 1'b0;
        fill_imem();
        idle_inputs();
        reset = 1'b1;
        #2;
        expect_v("init_ir1", S_IR1, 16'h000A);
        expect_v("init_pc",  S_PC,  16'h0000);
        expect_v("init_cnt", S_CNT, 16'h0000);
        check_sb();
        reset = 1'b0;

        // Straight-line fetch
        for (int k = 0; k < 4; k++) imem[k] = 8'h10 + 8'(k);
        CounterOn = 1'b1;
        set_loads(1'b1); IR1Sel = 1'b1; PCWrite = 1'b1;
        repeat (4) tick();
        expect_v("sl_ir1",   S_IR1,   16'h0013);
        expect_v("sl_ir2",   S_IR2,   16'h0012);
        expect_v("sl_ir3",   S_IR3,   16'h0011);
        expect_v("sl_ir4",   S_IR4,   16'h0010);
        expect_v("sl_pc",    S_PC,    16'h0004);
        expect_v("sl_pc1",   S_PC1,   16'h0003);
        expect_v("sl_pc2",   S_PC2,   16'h0002);
        expect_v("sl_pc3",   S_PC3,   16'h0001);
        expect_v("sl_instr", S_INSTR, 16'h0003);
        expect_v("sl_cnt",   S_CNT,   16'h0004);
        check_sb();
        idle_inputs();

        // Taken BZ
        do_reset();
        fill_imem();
        imem[5] = 8'hE5;
        Z = 1'b1;
        fetch_straight(5);
        expect_v("bz_pc_pre", S_PC, 16'h0005);
        check_sb();
        branch_seq("bz", 8'h05, 8'hE5, 1'b1, 8'h04);

        // Asynchronous reset while IR3 holds a branch
        do_reset();
        CounterOn = 1'b1;
        fetch_straight(5);
        CounterOn = 1'b1;
        set_loads(1'b1); IR1Sel = 1'b1; PCWrite = 1'b0;
        tick();
        IR1Sel = 1'b0;
        tick();
        tick();
        expect_v("rst_pre_ir3", S_IR3, 16'h00E5);
        expect_v("rst_pre_br",  S_BR,  16'h0001);
        expect_v("rst_pre_cnt", S_CNT, 16'h0008);
        check_sb();
        #2;
        reset = 1'b1;
        #1;
        expect_v("rst_ir1", S_IR1, 16'h000A);
        expect_v("rst_ir2", S_IR2, 16'h000A);
        expect_v("rst_ir3", S_IR3, 16'h000A);
        expect_v("rst_ir4", S_IR4, 16'h000A);
        expect_v("rst_pc",  S_PC,  16'h0000);
        expect_v("rst_pc3", S_PC3, 16'h0000);
        expect_v("rst_cnt", S_CNT, 16'h0000);
        expect_v("rst_br",  S_BR,  16'h0000);
        check_sb();
        idle_inputs();
        reset = 1'b0;

        // Not-taken BNZ and BPZ
        do_reset();
        fill_imem();
        imem[7] = 8'h39;
        Z = 1'b1; N = 1'b0;
        fetch_straight(7);
        branch_seq("bnz", 8'h07, 8'h39, 1'b0, 8'h08);
        do_reset();
        imem[7] = 8'h3D;
        Z = 1'b0; N = 1'b1;
        fetch_straight(7);
        branch_seq("bpz_nt", 8'h07, 8'h3D, 1'b0, 8'h08);

        // Address wrap
        do_reset();
        fill_imem();
        N = 1'b0;
        fetch_straight(255);
        expect_v("wrap_pc_ff", S_PC, 16'h00FF);
        check_sb();
        fetch_straight(1);
        expect_v("wrap_pc_00", S_PC, 16'h0000);
        check_sb();
        do_reset();
        imem[8'hFC] = 8'h7D;
        fetch_straight(252);
        branch_seq("bpz_wrap", 8'hFC, 8'h7D, 1'b1, 8'h04);

        // Hold: nothing changes with all controls low
        idle_inputs();
        repeat (10) tick();
        expect_v("hold_pc",  S_PC,  16'h0004);
        expect_v("hold_ir1", S_IR1, 16'h000A);
        expect_v("hold_ir3", S_IR3, 16'h000A);
        expect_v("hold_ir4", S_IR4, 16'h007D);
        expect_v("hold_pc1", S_PC1, 16'h00FC);
        expect_v("hold_pc3", S_PC3, 16'h00FC);
        expect_v("hold_cnt", S_CNT, 16'h0000);
        check_sb();

        // Counter saturation
        do_reset();
        CounterOn = 1'b1;
        repeat (65534) tick();
        expect_v("cnt_fffe", S_CNT, 16'hFFFE);
        check_sb();
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_v($sformatf("cnt_sat%0d", i), S_CNT, 16'hFFFF);
            check_sb();
        end
        CounterOn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
